// File: rtl/pixel_ctrl_pkg.sv
// rtl/pixel_ctrl_pkg.sv - shared state encoding and phase lengths for the pixel frame sequencer
package pixel_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ERASE   = 3'd1,
    ST_EXPOSE  = 3'd2,
    ST_CONVERT = 3'd3,
    ST_READ    = 3'd4
  } state_t;

  localparam int DEF_C_ERASE   = 5;
  localparam int DEF_C_EXPOSE  = 255;
  localparam int DEF_C_CONVERT = 255;
  localparam int DEF_C_READ    = 5;

  // IDLE has no length; a zero load keeps the timer quiet while idle.
  function automatic int phase_len(input state_t s, input int c_erase, input int c_expose,
                                   input int c_convert, input int c_read);
    case (s)
      ST_ERASE:   phase_len = c_erase;
      ST_EXPOSE:  phase_len = c_expose;
      ST_CONVERT: phase_len = c_convert;
      ST_READ:    phase_len = c_read;
      default:    phase_len = 0;
    endcase
  endfunction

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - loadable down-counter flagging the final cycle of a phase
module phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         last_cycle
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign last_cycle = (count == W'(1));

endmodule

// File: rtl/pixel_sensor_ctrl.sv
// rtl/pixel_sensor_ctrl.sv - ERASE/EXPOSE/CONVERT/READ frame sequencer with conversion ramp
module pixel_sensor_ctrl
  import pixel_ctrl_pkg::*;
#(
  parameter int BIT_DEPTH = 8,
  parameter int C_ERASE   = DEF_C_ERASE,
  parameter int C_EXPOSE  = DEF_C_EXPOSE,
  parameter int C_CONVERT = DEF_C_CONVERT,
  parameter int C_READ    = DEF_C_READ
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 continuous,
  input  logic                 abort,
  output logic                 power_enable,
  output logic                 write_enable,
  output logic                 counter_reset,
  output logic                 erase,
  output logic                 expose,
  output logic                 convert,
  output logic                 read_reset,
  output logic                 read,
  output logic [BIT_DEPTH-1:0] ramp_code,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int MAX_AB  = (C_ERASE > C_EXPOSE) ? C_ERASE : C_EXPOSE;
  localparam int MAX_CD  = (C_CONVERT > C_READ) ? C_CONVERT : C_READ;
  localparam int MAX_LEN = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW      = $clog2(MAX_LEN + 1);

  state_t        state;
  state_t        next_state;
  logic          last_cycle;
  logic          load;
  logic [CW-1:0] load_value;

  always_comb begin
    next_state = state;
    if (state == ST_IDLE) begin
      if (start && !abort) next_state = ST_ERASE;
    end else if (abort) begin
      next_state = ST_IDLE;
    end else if (last_cycle) begin
      case (state)
        ST_ERASE:   next_state = ST_EXPOSE;
        ST_EXPOSE:  next_state = ST_CONVERT;
        ST_CONVERT: next_state = ST_READ;
        ST_READ:    next_state = continuous ? ST_ERASE : ST_IDLE;
        default:    next_state = ST_IDLE;
      endcase
    end
  end

  // Every transition changes state, so a state change is exactly a phase entry.
  assign load       = (next_state != state);
  assign load_value = CW'(phase_len(next_state, C_ERASE, C_EXPOSE, C_CONVERT, C_READ));

  phase_timer #(
    .W(CW)
  ) u_phase_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_value (load_value),
    .last_cycle (last_cycle)
  );

  // Outputs are decoded from next_state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      power_enable  <= 1'b0;
      write_enable  <= 1'b0;
      counter_reset <= 1'b0;
      erase         <= 1'b0;
      expose        <= 1'b0;
      convert       <= 1'b0;
      read_reset    <= 1'b0;
      read          <= 1'b0;
      ramp_code     <= '0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      state         <= next_state;
      power_enable  <= (next_state == ST_EXPOSE) || (next_state == ST_CONVERT) ||
                       (next_state == ST_READ);
      write_enable  <= (next_state == ST_EXPOSE) || (next_state == ST_CONVERT);
      counter_reset <= (next_state == ST_ERASE) && (state != ST_ERASE);
      erase         <= (next_state == ST_ERASE);
      expose        <= (next_state == ST_EXPOSE);
      convert       <= (next_state == ST_CONVERT);
      read_reset    <= (next_state == ST_READ) && (state != ST_READ);
      read          <= (next_state == ST_READ);
      ramp_code     <= ((next_state == ST_CONVERT) && (state == ST_CONVERT)) ?
                       ramp_code + BIT_DEPTH'(1) : '0;
      busy          <= (next_state != ST_IDLE);
      frame_done    <= (state == ST_READ) && last_cycle && !abort;
    end
  end

endmodule

// File: tb/tb_pixel_sensor_ctrl.sv
// tb/tb_pixel_sensor_ctrl.sv - randomized and directed checks against a frame-timeline model
module tb_pixel_sensor_ctrl;

  localparam int BD    = 8;
  localparam int CE    = 5;
  localparam int CX    = 255;
  localparam int CC    = 255;
  localparam int CR    = 5;
  localparam int TOTAL = CE + CX + CC + CR;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          continuous = 1'b0;
  logic          abort = 1'b0;
  logic          power_enable, write_enable, counter_reset, erase, expose, convert;
  logic          read_reset, read, busy, frame_done;
  logic [BD-1:0] ramp_code;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pos = 0;
  bit fd_exp = 1'b0;
  int fd_cycles[$];
  int t0;
  int busy_drops;
  int guard;

  pixel_sensor_ctrl #(
    .BIT_DEPTH(BD), .C_ERASE(CE), .C_EXPOSE(CX), .C_CONVERT(CC), .C_READ(CR)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous), .abort(abort),
    .power_enable(power_enable), .write_enable(write_enable), .counter_reset(counter_reset),
    .erase(erase), .expose(expose), .convert(convert), .read_reset(read_reset),
    .read(read), .ramp_code(ramp_code), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic bit in_rng(input int lo, input int hi);
    return (pos >= lo) && (pos <= hi);
  endfunction

  // pos = 1-based cycle index within the current frame, 0 when idle.
  task automatic model_update();
    if (reset) begin
      pos = 0; fd_exp = 0;
    end else if (pos == 0) begin
      fd_exp = 0; pos = (start && !abort) ? 1 : 0;
    end else if (abort) begin
      pos = 0; fd_exp = 0;
    end else if (pos == TOTAL) begin
      fd_exp = 1; pos = continuous ? 1 : 0;
    end else begin
      fd_exp = 0; pos++;
    end
  endtask

  function automatic int exp_ramp();
    return in_rng(CE + CX + 1, CE + CX + CC) ? pos - (CE + CX + 1) : 0;
  endfunction

  task automatic compare_all();
    check("erase",         erase,         in_rng(1, CE));
    check("expose",        expose,        in_rng(CE + 1, CE + CX));
    check("convert",       convert,       in_rng(CE + CX + 1, CE + CX + CC));
    check("read",          read,          in_rng(CE + CX + CC + 1, TOTAL));
    check("power_enable",  power_enable,  in_rng(CE + 1, TOTAL));
    check("write_enable",  write_enable,  in_rng(CE + 1, CE + CX + CC));
    check("counter_reset", counter_reset, pos == 1);
    check("read_reset",    read_reset,    pos == CE + CX + CC + 1);
    check("ramp_code",     ramp_code,     exp_ramp());
    check("busy",          busy,          pos != 0);
    check("frame_done",    frame_done,    fd_exp);
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_update();
    #1;
    compare_all();
    if (frame_done === 1'b1) fd_cycles.push_back(cyc);
  endtask

  task automatic run_single_frame(input string tag);
    fd_cycles.delete();
    t0 = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (TOTAL + 10) tick();
    check({tag, "_fd_count"}, fd_cycles.size(), 1);
    if (fd_cycles.size() >= 1) check({tag, "_fd_cycle"}, fd_cycles[0] - t0, TOTAL + 1);
  endtask

  initial begin
    // Reset then idle
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (10) tick();

    run_single_frame("single");

    // Continuous mode: three back-to-back frames
    fd_cycles.delete();
    busy_drops = 0;
    continuous = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (fd_cycles.size() < 3 && guard < 4 * TOTAL) begin
      tick();
      if (busy !== 1'b1) busy_drops++;
      guard++;
    end
    check("cont_frames", fd_cycles.size(), 3);
    check("cont_busy_drops", busy_drops, 0);
    if (fd_cycles.size() >= 3) begin
      check("cont_spacing1", fd_cycles[1] - fd_cycles[0], TOTAL);
      check("cont_spacing2", fd_cycles[2] - fd_cycles[1], TOTAL);
    end
    continuous = 1'b0;
    guard = 0;
    while (pos != 0 && guard < 2 * TOTAL) begin
      tick();
      guard++;
    end
    check("cont_return_idle", busy, 0);
    repeat (3) tick();

    // Abort mid-CONVERT at ramp 100
    start = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (!(in_rng(CE + CX + 1, CE + CX + CC) && exp_ramp() == 100) && guard < 2 * TOTAL) begin
      tick();
      guard++;
    end
    check("abort_ramp_seen", ramp_code, 100);
    fd_cycles.delete();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_ramp", ramp_code, 0);
    repeat (TOTAL) tick();
    check("abort_no_fd", fd_cycles.size(), 0);
    run_single_frame("post_abort");

    // Abort wins over start in IDLE
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check("abort_start_idle", busy, 0);
    repeat (3) tick();

    // Start ignored while busy, reset mid-EXPOSE with start on the same edge
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (CE + 10) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_start_expose", expose, 1);
    repeat (5) tick();
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    check("reset_mid_expose", {busy, expose, power_enable}, 0);
    repeat (5) tick();
    check("reset_start_ignored", busy, 0);

    // Randomized traffic
    repeat (30000) begin
      start = ($urandom_range(0, 39) == 0);
      abort = ($urandom_range(0, 599) == 0);
      reset = ($urandom_range(0, 4999) == 0);
      if ($urandom_range(0, 299) == 0) continuous = ~continuous;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
